// File: rtl/intr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// intr_ctrl_pkg
// Shared definitions for the priority interrupt controller:
//   - state_e     : controller FSM states
//   - ADDR_STATUS : address of the STATUS register
//   - bit positions of the CHn enable bit and the STATUS busy/error bits
// -----------------------------------------------------------------------------
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_WAIT  = 2'd2,
        S_ERROR = 2'd3
    } state_e;

    localparam logic [7:0] ADDR_STATUS = 8'h80;

    localparam int CH_EN_BIT   = 7;
    localparam int ST_BUSY_BIT = 7;
    localparam int ST_ERR_BIT  = 6;

endpackage

// File: rtl/intr_prio_arb.sv
// -----------------------------------------------------------------------------
// intr_prio_arb
// Combinational arbiter: among eligible channels, picks the one with the highest
// priority; equal priorities resolve to the lowest channel index.
// Ports:
//   eligible     in   NUM_INTR         per-channel eligibility
//   prio_flat    in   NUM_INTR*PRIO_W  packed priorities, channel i at [i*PRIO_W +: PRIO_W]
//   any_eligible out  1                at least one channel is eligible
//   winner_id    out  ID_W             index of the winning channel (0 when none)
// -----------------------------------------------------------------------------
module intr_prio_arb #(
    parameter int NUM_INTR = 16,
    parameter int PRIO_W   = 4,
    parameter int ID_W     = 5
) (
    input  logic [NUM_INTR-1:0]        eligible,
    input  logic [NUM_INTR*PRIO_W-1:0] prio_flat,
    output logic                       any_eligible,
    output logic [ID_W-1:0]            winner_id
);

    logic [PRIO_W-1:0] best_prio;

    // Ascending scan with a strict '>' keeps the first (lowest-index) channel on ties.
    // NOTE: every always_comb output gets a default first; otherwise a path that
    // skips an assignment would infer a latch.
    always_comb begin
        best_prio    = '0;
        winner_id    = '0;
        any_eligible = 1'b0;
        for (int i = 0; i < NUM_INTR; i++) begin
            if (eligible[i] && (prio_flat[i*PRIO_W +: PRIO_W] > best_prio)) begin
                best_prio    = prio_flat[i*PRIO_W +: PRIO_W];
                winner_id    = ID_W'(i);
                any_eligible = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl_prio.sv
// -----------------------------------------------------------------------------
// intr_ctrl_prio
// Priority interrupt controller: NUM_INTR level request lines, per-channel
// enable/priority registers behind a psel-less APB-style slave, and an FSM that
// presents the winning channel ID until the processor acknowledges it.
// Optional feature: define INTR_TIMEOUT_EN to enable the service timeout
// (S_WAIT counter, STATUS error bit, S_ERROR state cleared via STATUS write).
// Ports:
//   pclk_i, prst_n_i        clock, asynchronous active-low reset
//   paddr_i, pwdata_i       register address / write data
//   pwrite_i, penable_i     write select, transfer request
//   prdata_o                registered read data
//   pready_o, perror_o      one-cycle completion pulse, error qualifier
//   intr_valid_o            interrupt presented
//   intr_to_service_o       ID of the presented channel
//   intr_serviced_i         processor acknowledge pulse
//   intr_active_i           peripheral request levels
// -----------------------------------------------------------------------------
module intr_ctrl_prio
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_INTR = 16,
    parameter int PRIO_W   = 4,
    parameter int ID_W     = 5,
    parameter int TIMEOUT  = 255
) (
    input  logic                pclk_i,
    input  logic                prst_n_i,
    input  logic [7:0]          paddr_i,
    input  logic [7:0]          pwdata_i,
    input  logic                pwrite_i,
    input  logic                penable_i,
    output logic [7:0]          prdata_o,
    output logic                pready_o,
    output logic                perror_o,
    output logic                intr_valid_o,
    output logic [ID_W-1:0]     intr_to_service_o,
    input  logic                intr_serviced_i,
    input  logic [NUM_INTR-1:0] intr_active_i
);

    localparam int IDX_W = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1;

    state_e                    state_q, state_d;
    logic                      ch_en_q   [NUM_INTR];
    logic [PRIO_W-1:0]         ch_prio_q [NUM_INTR];
    logic [NUM_INTR-1:0]       eligible;
    logic [NUM_INTR*PRIO_W-1:0] prio_flat;
    logic                      any_eligible;
    logic [ID_W-1:0]           winner_id;
    logic                      accept, ch_hit, st_hit, bad_addr, st_clr;
    logic [IDX_W-1:0]          ch_idx;
    logic [7:0]                rd_mux;
    logic                      err_q, timeout_hit;
    logic                      valid_d, load_id;
    logic                      unused_ok;

    // ---------------- register slave ----------------
    // A new transfer is only taken while no completion pulse is showing, so a
    // held penable_i completes one transfer every two cycles.
    assign accept   = penable_i & ~pready_o;
    assign ch_hit   = int'(paddr_i) < NUM_INTR;
    assign st_hit   = (paddr_i == ADDR_STATUS);
    assign bad_addr = ~ch_hit & ~st_hit;
    assign ch_idx   = paddr_i[IDX_W-1:0];
    assign st_clr   = accept & pwrite_i & st_hit & pwdata_i[ST_ERR_BIT];

    // Bits not covered by any field are deliberately dropped.
    assign unused_ok = ^{pwdata_i, st_clr};

    always_comb begin
        rd_mux = '0;
        if (ch_hit) begin
            rd_mux[CH_EN_BIT]    = ch_en_q[ch_idx];
            rd_mux[PRIO_W-1:0]   = ch_prio_q[ch_idx];
        end else if (st_hit) begin
            rd_mux[ST_BUSY_BIT]  = (state_q != S_IDLE);
            rd_mux[ST_ERR_BIT]   = err_q;
            rd_mux[ID_W-1:0]     = intr_to_service_o;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            pready_o <= 1'b0;
            perror_o <= 1'b0;
            prdata_o <= '0;
            // NOTE: the channel array is a handful of control flops, not a RAM,
            // so it is reset like any other register.
            for (int i = 0; i < NUM_INTR; i++) begin
                ch_en_q[i]   <= 1'b0;
                ch_prio_q[i] <= '0;
            end
        end else begin
            pready_o <= accept;
            perror_o <= accept & bad_addr;
            prdata_o <= (accept && !pwrite_i) ? rd_mux : 8'h00;
            if (accept && pwrite_i && ch_hit) begin
                ch_en_q[ch_idx]   <= pwdata_i[CH_EN_BIT];
                ch_prio_q[ch_idx] <= pwdata_i[PRIO_W-1:0];
            end
        end
    end

    // ---------------- arbitration ----------------
    always_comb begin
        eligible  = '0;
        prio_flat = '0;
        for (int i = 0; i < NUM_INTR; i++) begin
            eligible[i]                  = intr_active_i[i] & ch_en_q[i] & (ch_prio_q[i] != '0);
            prio_flat[i*PRIO_W +: PRIO_W] = ch_prio_q[i];
        end
    end

    intr_prio_arb #(
        .NUM_INTR (NUM_INTR),
        .PRIO_W   (PRIO_W),
        .ID_W     (ID_W)
    ) u_arb (
        .eligible     (eligible),
        .prio_flat    (prio_flat),
        .any_eligible (any_eligible),
        .winner_id    (winner_id)
    );

    // ---------------- service timeout ----------------
`ifdef INTR_TIMEOUT_EN
    logic [15:0] wait_cnt_q;

    assign timeout_hit = (state_q == S_WAIT) && (wait_cnt_q == 16'(TIMEOUT - 1));

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 16'd1 : 16'd0;
            // An ack on the last cycle still wins over the timeout.
            if (timeout_hit && !intr_serviced_i) err_q <= 1'b1;
            else if (st_clr)                     err_q <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_q       = 1'b0;
`endif

    // ---------------- controller FSM ----------------
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        valid_d = intr_valid_o;
        load_id = 1'b0;
        case (state_q)
            S_IDLE: if (any_eligible) state_d = S_ARB;
            S_ARB: begin
                // The request may have vanished during the arbitration cycle.
                if (any_eligible) begin
                    state_d = S_WAIT;
                    valid_d = 1'b1;
                    load_id = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (intr_serviced_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    valid_d = 1'b0;
                    state_d = S_ERROR;
                end
            end
            S_ERROR: if (!err_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The presented ID is held after the ack so STATUS still shows the last channel.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            intr_valid_o      <= 1'b0;
            intr_to_service_o <= '0;
        end else begin
            intr_valid_o <= valid_d;
            if (load_id) intr_to_service_o <= winner_id;
        end
    end

endmodule
